// File: rtl/intpol2_src_pkg.sv
// Shared types and constants for the intpol2 IQ sample-source sequencer.
//   state_t     : sequencer states, also exported for debug
//   MODE_*      : encodings of cfg_mode_i (2'b11 behaves as MODE_SINGLE)
package intpol2_src_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_LOOP   = 2'b01;
    localparam logic [1:0] MODE_FLUSH  = 2'b10;

endpackage

// File: rtl/intpol2_src_addr_gen.sv
// Window address generator for the sample-source sequencer.
// Holds the sample index, forms (offset + index) mod 2**MEM_ADDR_W and
// flags the last sample of the window.
//   clk, rst_a : clock, asynchronous active-low reset
//   clear_i    : restart the window at index 0 (accepted start)
//   adv_i      : a read was issued this cycle; step the index
//   offset_i   : latched window start address
//   depth_i    : latched window length (>= 1 whenever adv_i is used)
//   addr_o     : memory read address for the current index
//   last_o     : current index is depth_i-1
module intpol2_src_addr_gen #(
    parameter int MEM_ADDR_W = 7
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  clear_i,
    input  logic                  adv_i,
    input  logic [MEM_ADDR_W-1:0] offset_i,
    input  logic [7:0]            depth_i,
    output logic [MEM_ADDR_W-1:0] addr_o,
    output logic                  last_o
);

    // Sum is formed at least 8 bits wide so the full index takes part,
    // then truncated: truncation is the modulo wrap of the address space.
    localparam int SW = (MEM_ADDR_W > 8) ? MEM_ADDR_W : 8;

    logic [7:0]    idx_q;
    logic [SW-1:0] sum;

    assign sum    = SW'(offset_i) + SW'(idx_q);
    assign addr_o = sum[MEM_ADDR_W-1:0];
    assign last_o = (idx_q == (depth_i - 8'd1));

    // The index wraps to 0 after the last sample; loop mode relies on this,
    // single-pass modes leave RUN at that point so the value is unused.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            idx_q <= '0;
        end else if (clear_i) begin
            idx_q <= '0;
        end else if (adv_i) begin
            idx_q <= last_o ? 8'd0 : idx_q + 8'd1;
        end
    end

endmodule

// File: rtl/intpol2_iq_src_ctrl.sv
// Sample-memory to interpolator-FIFO sequencer.
// On an accepted start it reads a window of the sample memory (1-cycle
// synchronous read) and writes each word to the interpolator input FIFO,
// optionally followed by FLUSH_LEN zero words, then reports completion.
//   clk, rst_a        : clock, asynchronous active-low reset
//   start_i, stop_i   : start request (IDLE/DONE only), stop request (RUN only)
//   afull_i           : FIFO almost-full, throttles reads and flush writes
//   cfg_depth_i/_offset_i/_mode_i : window config, latched at start
//   mem_rd_o, mem_addr_o, mem_data_i : sample memory read port
//   fifo_we_o, fifo_data_o : FIFO write port
//   busy_o, done_o, int_o, cfg_err_o, count_o : status
//   dbg_state_o       : current sequencer state (state_t encoding)
//
// Flow control: afull_i acts as an inverted ready. A memory read (and hence
// a later FIFO write) is only issued in a cycle where afull_i is low; a read
// already in flight always completes its write one cycle later, which the
// FIFO's two words of slack absorb. Flush writes are issued directly and
// also only while afull_i is low.
module intpol2_iq_src_ctrl
    import intpol2_src_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_ADDR_W = 7,
    parameter int FLUSH_LEN  = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  afull_i,
    input  logic [7:0]            cfg_depth_i,
    input  logic [7:0]            cfg_offset_i,
    input  logic [1:0]            cfg_mode_i,
    output logic                  mem_rd_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  fifo_we_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  int_o,
    output logic                  cfg_err_o,
    output logic [CNT_W-1:0]      count_o,
    output logic [2:0]            dbg_state_o
);

    localparam int FW = $clog2(FLUSH_LEN + 1);

    state_t                state_q;
    logic                  rd_vld_q;
    logic [7:0]            depth_q;
    logic [MEM_ADDR_W-1:0] offset_q;
    logic [1:0]            mode_q;
    logic                  stopped_q;
    logic [FW-1:0]         flush_cnt_q;
    logic [CNT_W-1:0]      count_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  int_q;
    logic                  err_q;

    logic start_ok;
    logic flush_we;
    logic last;
    logic loop_mode;
    logic flush_mode;

    assign start_ok   = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign loop_mode  = (mode_q == MODE_LOOP);
    assign flush_mode = (mode_q == MODE_FLUSH);

    // A stop in RUN suppresses the read of that same cycle.
    assign mem_rd_o = (state_q == RUN) && !afull_i && !stop_i;
    assign flush_we = (state_q == FLUSH) && !afull_i;

    // rd_vld_q is only ever set by a RUN read, so it cannot coincide with
    // a flush write: DRAIN separates the two phases.
    assign fifo_we_o   = rd_vld_q || flush_we;
    assign fifo_data_o = rd_vld_q ? mem_data_i : '0;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign int_o       = int_q;
    assign cfg_err_o   = err_q;
    assign count_o     = count_q;
    assign dbg_state_o = state_q;

    intpol2_src_addr_gen #(
        .MEM_ADDR_W (MEM_ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_a    (rst_a),
        .clear_i  (start_ok),
        .adv_i    (mem_rd_o),
        .offset_i (offset_q),
        .depth_i  (depth_q),
        .addr_o   (mem_addr_o),
        .last_o   (last)
    );

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q     <= IDLE;
            rd_vld_q    <= 1'b0;
            depth_q     <= '0;
            offset_q    <= '0;
            mode_q      <= '0;
            stopped_q   <= 1'b0;
            flush_cnt_q <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            int_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            int_q    <= 1'b0;
            rd_vld_q <= mem_rd_o;

            if (fifo_we_o && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        depth_q     <= cfg_depth_i;
                        offset_q    <= cfg_offset_i[MEM_ADDR_W-1:0];
                        mode_q      <= cfg_mode_i;
                        stopped_q   <= 1'b0;
                        flush_cnt_q <= '0;
                        count_q     <= '0;
                        if (cfg_depth_i == 8'd0) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            int_q   <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (stop_i) begin
                        stopped_q <= 1'b1;
                        state_q   <= DRAIN;
                    end else if (mem_rd_o && last && !loop_mode) begin
                        state_q <= DRAIN;
                    end
                end

                // One cycle for the final in-flight read to reach the FIFO.
                DRAIN: begin
                    if (flush_mode && !stopped_q) begin
                        state_q <= FLUSH;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        int_q   <= 1'b1;
                    end
                end

                FLUSH: begin
                    if (flush_we) begin
                        if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            int_q   <= 1'b1;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intpol2_iq_src_ctrl.sv
// Directed bench for intpol2_iq_src_ctrl. A sample memory model answers
// reads; each test pushes the words the FIFO must receive onto exp_q and a
// single negedge process checks every write against it.
module tb_intpol2_iq_src_ctrl;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int FL = 4;
    localparam int CW = 16;

    logic          clk;
    logic          rst_a;
    logic          start_i;
    logic          stop_i;
    logic          afull_i;
    logic [7:0]    cfg_depth_i;
    logic [7:0]    cfg_offset_i;
    logic [1:0]    cfg_mode_i;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_i;
    logic          fifo_we_o;
    logic [DW-1:0] fifo_data_o;
    logic          busy_o;
    logic          done_o;
    logic          int_o;
    logic          cfg_err_o;
    logic [CW-1:0] count_o;
    logic [2:0]    dbg_state_o;

    intpol2_iq_src_ctrl #(
        .DATA_WIDTH (DW),
        .MEM_ADDR_W (AW),
        .FLUSH_LEN  (FL),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_a        (rst_a),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .afull_i      (afull_i),
        .cfg_depth_i  (cfg_depth_i),
        .cfg_offset_i (cfg_offset_i),
        .cfg_mode_i   (cfg_mode_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .fifo_we_o    (fifo_we_o),
        .fifo_data_o  (fifo_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .int_o        (int_o),
        .cfg_err_o    (cfg_err_o),
        .count_o      (count_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- sample memory model ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        mem_data_i = '0;
    end
    always @(posedge clk) begin
        if (mem_rd_o === 1'b1) mem_data_i <= mem[mem_addr_o];
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  t0 = 0;
    int  wr_cnt, wr_first, wr_last, int_cnt;
    bit  wr_at [0:63];
    bit  prev_rd = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] e;
        int rel;
        if (rst_a !== 1'b1) begin
            prev_rd = 1'b0;
        end else begin
            rel = cyc - t0;
            if (mem_rd_o === 1'b1) check("no_read_while_afull", afull_i, 0);
            // Memory data reaches the FIFO exactly one cycle after its read.
            if (prev_rd) check("write_follows_read", fifo_we_o, 1);
            if (fifo_we_o === 1'b1) begin
                if (!prev_rd) check("flush_write_while_afull", afull_i, 0);
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("fifo_data", fifo_data_o, e);
                end
                if (wr_cnt == 0) wr_first = rel;
                wr_last = rel;
                if (rel >= 0 && rel < 64) wr_at[rel] = 1'b1;
                wr_cnt++;
            end
            if (int_o === 1'b1) int_cnt++;
            prev_rd = (mem_rd_o === 1'b1);
        end
    end

    // ---------------- model: expected FIFO stream ----------------
    task automatic push_window(input int depth, input int offset, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(mem[(offset + (i % depth)) % (1 << AW)]);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('0);
    endtask

    // ---------------- drivers ----------------
    task automatic do_start(input logic [7:0] d, input logic [7:0] o,
                            input logic [1:0] m, input logic with_stop);
        @(posedge clk); #1;
        cfg_depth_i  = d;
        cfg_offset_i = o;
        cfg_mode_i   = m;
        start_i      = 1'b1;
        stop_i       = with_stop;
        wr_cnt = 0; wr_first = -1; wr_last = -1; int_cnt = 0;
        for (int i = 0; i < 64; i++) wr_at[i] = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        t0      = cyc;
        // Config must have been latched; scramble it.
        cfg_depth_i  = 8'($urandom_range(0, 255));
        cfg_offset_i = 8'($urandom_range(0, 255));
        cfg_mode_i   = 2'($urandom_range(0, 3));
    endtask

    task automatic stop_after_reads(input string tag, input int n);
        int seen = 0;
        int g = 0;
        while (seen < n && g < 300) begin
            @(negedge clk);
            if (mem_rd_o === 1'b1) seen++;
            g++;
        end
        check({tag, "_reads_before_stop"}, seen, n);
        @(posedge clk); #1 stop_i = 1'b1;
        @(posedge clk); #1 stop_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int done_cyc);
        int k = 0;
        @(negedge clk);
        while (done_o !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_reached"}, done_o, 1);
        done_cyc = cyc - t0;
    endtask

    task automatic finish_checks(input string tag, input int exp_cnt, input logic exp_err);
        check({tag, "_busy_at_done"}, busy_o, 0);
        check({tag, "_count"}, count_o, exp_cnt);
        check({tag, "_cfg_err"}, cfg_err_o, exp_err);
        check({tag, "_all_written"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_int_pulses"}, int_cnt, 1);
        check({tag, "_int_low_after"}, int_o, 0);
        check({tag, "_done_sticky"}, done_o, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {mem_rd_o, mem_addr_o, fifo_we_o, fifo_data_o, busy_o,
                    done_o, int_o, cfg_err_o, count_o}, 64'd0);
    endtask

    // ---------------- tests ----------------
    initial begin
        int dc;
        rst_a = 1'b0; start_i = 1'b0; stop_i = 1'b0; afull_i = 1'b0;
        cfg_depth_i = '0; cfg_offset_i = '0; cfg_mode_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk); #1 rst_a = 1'b1;

        // 1: single pass 0..9, start with simultaneous stop (start wins)
        push_window(10, 0, 10);
        do_start(8'd10, 8'd0, 2'b00, 1'b1);
        @(negedge clk);
        check("t1_start_clears_done", {busy_o, done_o}, 2'b10);
        wait_done("t1", dc);
        check("t1_done_cycle", dc, 11);
        finish_checks("t1", 10, 1'b0);
        check("t1_first_write_cycle", wr_first, 1);
        check("t1_last_write_cycle", wr_last, 10);

        // 2: address wrap 124..127,0..3
        push_window(8, 124, 8);
        do_start(8'd8, 8'd124, 2'b00, 1'b0);
        wait_done("t2", dc);
        finish_checks("t2", 8, 1'b0);

        // 3: afull high in cycles 5..9, ignored start at cycle 12
        push_window(20, 0, 20);
        do_start(8'd20, 8'd0, 2'b00, 1'b0);
        repeat (5) @(posedge clk);
        #1 afull_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 afull_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 start_i = 1'b1; cfg_depth_i = 8'd3; cfg_mode_i = 2'b10;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_done("t3", dc);
        finish_checks("t3", 20, 1'b0);
        check("t3_inflight_write", wr_at[5], 1);
        check("t3_no_write_after_inflight", wr_at[6], 0);
        check("t3_last_write_cycle", wr_last, 25);

        // 4a: flush mode depth 3 -> 0,1,2,0,0,0,0
        push_window(3, 0, 3);
        push_zeros(FL);
        do_start(8'd3, 8'd0, 2'b10, 1'b0);
        wait_done("t4a", dc);
        finish_checks("t4a", 7, 1'b0);
        check("t4a_last_write_cycle", wr_last, 7);

        // 4b: same, afull high in cycles 5,6 (inside FLUSH)
        push_window(3, 0, 3);
        push_zeros(FL);
        do_start(8'd3, 8'd0, 2'b10, 1'b0);
        repeat (5) @(posedge clk);
        #1 afull_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 afull_i = 1'b0;
        wait_done("t4b", dc);
        finish_checks("t4b", 7, 1'b0);
        check("t4b_first_flush_write", wr_at[4], 1);
        check("t4b_stalled_flush", {wr_at[5], wr_at[6]}, 2'b00);
        check("t4b_last_write_cycle", wr_last, 9);

        // 5a: loop mode depth 4, stop after 10 reads
        push_window(4, 0, 10);
        do_start(8'd4, 8'd0, 2'b01, 1'b0);
        stop_after_reads("t5a", 10);
        wait_done("t5a", dc);
        finish_checks("t5a", 10, 1'b0);

        // 5b: flush mode stopped early -> no zero words
        push_window(20, 40, 5);
        do_start(8'd20, 8'd40, 2'b10, 1'b0);
        stop_after_reads("t5b", 5);
        wait_done("t5b", dc);
        finish_checks("t5b", 5, 1'b0);

        // mode 11 behaves as single pass
        push_window(3, 100, 3);
        do_start(8'd3, 8'd100, 2'b11, 1'b0);
        wait_done("m11", dc);
        finish_checks("m11", 3, 1'b0);

        // 6a: depth 0 -> DONE next cycle with cfg_err, no reads
        do_start(8'd0, 8'd5, 2'b00, 1'b0);
        @(negedge clk);
        check("t6a_cycle0_status", {busy_o, done_o, int_o, cfg_err_o, mem_rd_o}, 5'b01110);
        @(negedge clk);
        check("t6a_cycle1_status", {int_o, mem_rd_o, fifo_we_o, done_o}, 4'b0001);
        check("t6a_int_pulses", int_cnt, 1);
        check("t6a_no_writes", wr_cnt, 0);
        push_window(5, 3, 5);
        do_start(8'd5, 8'd3, 2'b00, 1'b0);
        wait_done("t6a_next", dc);
        finish_checks("t6a_next", 5, 1'b0);

        // 6b: reset mid-RUN, then a clean run from index 0
        push_window(20, 0, 20);
        do_start(8'd20, 8'd0, 2'b00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        exp_q.delete();
        rst_a = 1'b0;
        @(negedge clk);
        check_all_zero("t6b_outputs_in_reset");
        @(posedge clk); #1 rst_a = 1'b1;
        repeat (3) @(negedge clk);
        check("t6b_idle_after_reset", {busy_o, fifo_we_o, mem_rd_o, count_o}, 64'd0);
        push_window(4, 10, 4);
        do_start(8'd4, 8'd10, 2'b00, 1'b0);
        wait_done("t6b", dc);
        finish_checks("t6b", 4, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
